// File: rtl/axi4_master.sv
// Single-outstanding AXI4 initiator: one local command becomes one AXI4 read or write burst,
// and a one-cycle done pulse carries the response. Write data and read data pass straight through.
module axi4_master #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [1:0]        cmd_burst,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic              done,
  output logic [1:0]        resp,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [1:0]        AWBURST,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [DATA_W-1:0] WDATA,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [1:0]        ARBURST,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [2:0]        state_dbg
);

  // Handshake rule on every channel (cmd, local streams, AXI): a transfer happens on the
  // rising edge where VALID && READY; a raised VALID holds with a stable payload until then.

  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        burst_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [8:0]        cnt;
  logic [8:0]        cnt_inc;
  logic              illegal;
  logic              wrap_len_ok;
  logic              w_fire;
  logic              r_fire;
  logic              at_last;

  assign wrap_len_ok = (cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                       (cmd_len == 8'd7) || (cmd_len == 8'd15);
  assign illegal     = (cmd_size > 3'(MAX_SIZE)) || (cmd_burst == 2'b11) ||
                       ((cmd_burst == 2'b10) && !wrap_len_ok);

  // The counter saturates instead of wrapping so a runaway read burst still reads as "too long".
  assign cnt_inc = (cnt == 9'h1FF) ? cnt : cnt + 9'd1;
  assign at_last = (cnt == {1'b0, len_q});

  assign AWADDR  = addr_q;
  assign AWBURST = burst_q;
  assign AWLEN   = len_q;
  assign AWSIZE  = size_q;
  assign ARADDR  = addr_q;
  assign ARBURST = burst_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = size_q;

  assign WVALID   = (state == S_W) && wr_valid;
  assign WDATA    = wr_data;
  assign WLAST    = (state == S_W) && at_last;
  assign wr_ready = (state == S_W) && WREADY;
  assign w_fire   = WVALID && WREADY;

  assign RREADY   = (state == S_R) && rd_ready;
  assign rd_valid = (state == S_R) && RVALID;
  assign rd_last  = (state == S_R) && RLAST;
  assign rd_data  = RDATA;
  assign r_fire   = RVALID && RREADY;

  assign state_dbg = state;

  always_ff @(posedge ACLK) begin
    if (!ARESET) begin
      state     <= S_IDLE;
      cnt       <= 9'd0;
      resp      <= 2'b00;
      cmd_ready <= 1'b0;
      AWVALID   <= 1'b0;
      ARVALID   <= 1'b0;
      BREADY    <= 1'b0;
      done      <= 1'b0;
      addr_q    <= '0;
      burst_q   <= 2'b00;
      len_q     <= 8'd0;
      size_q    <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            addr_q    <= cmd_addr;
            burst_q   <= cmd_burst;
            len_q     <= cmd_len;
            size_q    <= cmd_size;
            cnt       <= 9'd0;
            resp      <= 2'b00;
            cmd_ready <= 1'b0;
            if (illegal) begin
              resp  <= 2'b10;
              done  <= 1'b1;
              state <= S_DONE;
            end else if (cmd_write) begin
              AWVALID <= 1'b1;
              state   <= S_AW;
            end else begin
              ARVALID <= 1'b1;
              state   <= S_AR;
            end
          end
        end
        S_AW: begin
          if (AWREADY) begin
            AWVALID <= 1'b0;
            state   <= S_W;
          end
        end
        S_W: begin
          if (w_fire) begin
            cnt <= cnt_inc;
            if (at_last) begin
              BREADY <= 1'b1;
              state  <= S_B;
            end
          end
        end
        S_B: begin
          if (BVALID) begin
            resp   <= BRESP;
            BREADY <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_AR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            state   <= S_R;
          end
        end
        S_R: begin
          // The burst only ends on RLAST; a beat count disagreeing with len flags an error.
          if (r_fire) begin
            cnt <= cnt_inc;
            if (RLAST) begin
              resp  <= at_last ? RRESP : 2'b10;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_master.sv
// Directed bench for axi4_master: a small AXI4 memory slave, a local write-data source and
// read-data sink, and immediate assertions at each checkpoint with hand-computed expectations.
module tb_axi4_master;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [1:0]        cmd_burst;
  logic [7:0]        cmd_len;
  logic [2:0]        cmd_size;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_last, rd_ready;
  logic              done;
  logic [1:0]        resp;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [1:0]        AWBURST, ARBURST;
  logic [7:0]        AWLEN, ARLEN;
  logic [2:0]        AWSIZE, ARSIZE;
  logic              AWVALID, AWREADY, ARVALID, ARREADY;
  logic [DATA_W-1:0] WDATA, RDATA;
  logic              WLAST, WVALID, WREADY;
  logic [1:0]        BRESP, RRESP;
  logic              BVALID, BREADY;
  logic              RLAST, RVALID, RREADY;
  logic [2:0]        state_dbg;

  axi4_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .resp(resp),
    .AWADDR(AWADDR), .AWBURST(AWBURST), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARBURST(ARBURST), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic [DATA_W-1:0] wd_q[$];
  logic [DATA_W-1:0] mem [8];

  logic       rd_toggle = 1'b0, wr_gap = 1'b0, w_stall = 1'b0, rlast_early = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;
  int flush_req = 0;

  int w_beats = 0, wlast_cnt = 0, wlast_at = 0;
  int rlast_cnt = 0, rlast_idx = -1;
  int done_cnt = 0, aw_seen = 0, ar_seen = 0;
  int viol = 0, rr_mis = 0, wv_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- AXI4 memory slave ----------------
  function automatic logic [4:0] next_addr(input logic [4:0] a, input logic [1:0] b,
                                           input logic [7:0] l, input logic [2:0] s);
    logic [4:0] step;
    logic [4:0] wmask;
    step  = 5'(1 << s);
    wmask = 5'(((int'(l) + 1) << s) - 1);
    case (b)
      2'b00:   return a;
      2'b10:   return (a & ~wmask) | ((a + step) & wmask);
      default: return a + step;
    endcase
  endfunction

  logic [4:0] wa, ra;
  logic [1:0] wb, rb;
  logic [7:0] wl, rl;
  logic [2:0] ws, rs;
  int         rbeat;

  always @(posedge ACLK) begin
    if (!ARESET) begin
      AWREADY <= 1'b0; WREADY <= 1'b0; BVALID <= 1'b0; BRESP <= 2'b00;
      ARREADY <= 1'b0; RVALID <= 1'b0; RLAST <= 1'b0; RDATA <= '0; RRESP <= 2'b00;
    end else begin
      AWREADY <= AWVALID && !AWREADY;
      if (AWVALID && AWREADY) begin
        wa <= AWADDR; wb <= AWBURST; wl <= AWLEN; ws <= AWSIZE;
      end
      WREADY <= w_stall ? !WREADY : 1'b1;
      if (WVALID && WREADY) begin
        mem[wa[4:2]] <= WDATA;
        wa <= next_addr(wa, wb, wl, ws);
        if (WLAST) begin
          BVALID <= 1'b1;
          BRESP  <= bresp_cfg;
        end
      end
      if (BVALID && BREADY) BVALID <= 1'b0;
      ARREADY <= ARVALID && !ARREADY;
      RRESP   <= 2'b00;
      if (ARVALID && ARREADY) begin
        RVALID <= 1'b1;
        RDATA  <= mem[ARADDR[4:2]];
        RLAST  <= (ARLEN == 8'd0);
        ra <= next_addr(ARADDR, ARBURST, ARLEN, ARSIZE);
        rb <= ARBURST; rl <= ARLEN; rs <= ARSIZE; rbeat <= 0;
      end else if (RVALID && RREADY) begin
        if (RLAST) begin
          RVALID <= 1'b0;
          RLAST  <= 1'b0;
        end else begin
          RDATA <= mem[ra[4:2]];
          ra    <= next_addr(ra, rb, rl, rs);
          rbeat <= rbeat + 1;
          RLAST <= (rbeat + 1 == int'(rl)) || (rlast_early && (rbeat + 1 == 1));
        end
      end
    end
  end

  // ---------------- local write source / read sink ----------------
  int   wd_ptr = 0;
  int   flush_seen = 0;
  logic w_fire, gap_ph = 1'b0;

  always begin
    @(posedge ACLK);
    w_fire = wr_valid && wr_ready;
    @(negedge ACLK);
    if (w_fire) wd_ptr++;
    if (flush_seen != flush_req) begin
      flush_seen = flush_req;
      wd_ptr     = wd_q.size();
      wr_valid   = 1'b0;
    end else if (!(wr_valid && !w_fire)) begin
      gap_ph   = !gap_ph;
      wr_valid = (wd_ptr < wd_q.size()) && !(wr_gap && gap_ph);
      wr_data  = (wd_ptr < wd_q.size()) ? wd_q[wd_ptr] : '0;
    end
  end

  always @(negedge ACLK) rd_ready = rd_toggle ? !rd_ready : 1'b1;

  // ---------------- monitors ----------------
  logic              p_rst = 1'b0, p_awv = 1'b0, p_awr = 1'b0, p_arv = 1'b0, p_arr = 1'b0;
  logic              p_wv = 1'b0, p_wr = 1'b0, p_wlast = 1'b0;
  logic [ADDR_W-1:0] p_awaddr, p_araddr;
  logic [7:0]        p_awlen, p_arlen;
  logic [DATA_W-1:0] p_wdata;

  always @(posedge ACLK) begin
    if (rd_valid && rd_ready) begin
      got_q.push_back(rd_data);
      if (rd_last) begin
        rlast_cnt++;
        rlast_idx = got_q.size() - 1;
      end
    end
    if (WVALID && WREADY) begin
      w_beats++;
      if (WLAST) begin
        wlast_cnt++;
        wlast_at = w_beats;
      end
    end
    if (done) done_cnt++;
    if (AWVALID) aw_seen++;
    if (ARVALID) ar_seen++;
    if (RVALID && (RREADY !== rd_ready)) rr_mis++;
    if (WVALID && !wr_valid) wv_mis++;
    if (ARESET && p_rst) begin
      if (p_awv && !p_awr && (!AWVALID || AWADDR !== p_awaddr || AWLEN !== p_awlen)) viol++;
      if (p_arv && !p_arr && (!ARVALID || ARADDR !== p_araddr || ARLEN !== p_arlen)) viol++;
      if (p_wv && !p_wr && (!WVALID || WDATA !== p_wdata || WLAST !== p_wlast)) viol++;
    end
    p_rst = ARESET;
    p_awv = AWVALID; p_awr = AWREADY; p_awaddr = AWADDR; p_awlen = AWLEN;
    p_arv = ARVALID; p_arr = ARREADY; p_araddr = ARADDR; p_arlen = ARLEN;
    p_wv = WVALID; p_wr = WREADY; p_wdata = WDATA; p_wlast = WLAST;
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic w, input logic [4:0] a, input logic [1:0] b,
                          input logic [7:0] l, input logic [2:0] s, output logic ok);
    @(negedge ACLK);
    cmd_write = w; cmd_addr = a; cmd_burst = b; cmd_len = l; cmd_size = s;
    cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge ACLK);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output logic [1:0] r, output logic ok);
    ok = 1'b0;
    r  = 2'bxx;
    for (int i = 0; i < max; i++) begin
      @(posedge ACLK);
      if (done) begin
        r  = resp;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_write(input string tag, input logic [4:0] a, input logic [1:0] b,
                           input logic [7:0] l, input logic [1:0] exp_resp);
    logic ok;
    logic [1:0] r;
    int b0, l0, d0;
    b0 = w_beats; l0 = wlast_cnt; d0 = done_cnt;
    send_cmd(1'b1, a, b, l, 3'd2, ok);
    check({tag, "_accept"}, 32'(ok), 32'd1);
    check({tag, "_awvalid_lat"}, 32'(AWVALID), 32'd1);
    wait_done(200, r, ok);
    check({tag, "_done"}, 32'(ok), 32'd1);
    check({tag, "_resp"}, 32'(r), 32'(exp_resp));
    @(negedge ACLK);
    check({tag, "_beats"}, 32'(w_beats - b0), 32'(int'(l) + 1));
    check({tag, "_wlast_cnt"}, 32'(wlast_cnt - l0), 32'd1);
    check({tag, "_wlast_pos"}, 32'(wlast_at - b0), 32'(int'(l) + 1));
    check({tag, "_done_pulse"}, 32'(done_cnt - d0), 32'd1);
  endtask

  // exp_q holds the read data expected for this burst, in order.
  task automatic run_read(input string tag, input logic [4:0] a, input logic [1:0] b,
                          input logic [7:0] l, input logic [1:0] exp_resp);
    logic ok;
    logic [1:0] r;
    logic [DATA_W-1:0] g, e;
    int base, n_exp, rl0;
    base = got_q.size(); rl0 = rlast_cnt; n_exp = exp_q.size();
    send_cmd(1'b0, a, b, l, 3'd2, ok);
    check({tag, "_accept"}, 32'(ok), 32'd1);
    check({tag, "_arvalid_lat"}, 32'(ARVALID), 32'd1);
    wait_done(300, r, ok);
    check({tag, "_done"}, 32'(ok), 32'd1);
    check({tag, "_resp"}, 32'(r), 32'(exp_resp));
    @(negedge ACLK);
    check({tag, "_beats"}, 32'(got_q.size() - base), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      e = exp_q.pop_front();
      g = (base + i < got_q.size()) ? got_q[base + i] : 'x;
      check($sformatf("%s_data%0d", tag, i), g, e);
    end
    check({tag, "_rlast_cnt"}, 32'(rlast_cnt - rl0), 32'd1);
    check({tag, "_rlast_pos"}, 32'(rlast_idx - base), 32'(n_exp - 1));
  endtask

  task automatic run_illegal(input string tag, input logic w, input logic [1:0] b,
                             input logic [7:0] l, input logic [2:0] s);
    logic ok;
    int a0, r0;
    a0 = aw_seen; r0 = ar_seen;
    send_cmd(w, 5'h00, b, l, s, ok);
    check({tag, "_accept"}, 32'(ok), 32'd1);
    check({tag, "_done_hi"}, 32'(done), 32'd1);
    check({tag, "_resp"}, 32'(resp), 32'd2);
    check({tag, "_busy"}, 32'(cmd_ready), 32'd0);
    @(negedge ACLK);
    check({tag, "_done_lo"}, 32'(done), 32'd0);
    check({tag, "_ready_back"}, 32'(cmd_ready), 32'd1);
    check({tag, "_no_axvalid"}, 32'((aw_seen - a0) + (ar_seen - r0)), 32'd0);
  endtask

  function automatic logic [31:0] out_vec();
    return {22'd0, cmd_ready, AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY,
            done, rd_valid, wr_ready};
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic ok;
    int b0, d0;
    ARESET = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_burst = 2'b00; cmd_len = 8'd0; cmd_size = 3'd0;

    repeat (3) @(negedge ACLK);
    check("rst_outputs", out_vec(), 32'd0);
    check("rst_resp", 32'(resp), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    ARESET = 1'b1;
    @(negedge ACLK);

    wd_q.push_back(32'h11111111); wd_q.push_back(32'h22222222);
    wd_q.push_back(32'h33333333); wd_q.push_back(32'h44444444);
    run_write("wr_incr", 5'h00, 2'b01, 8'd3, 2'b00);

    exp_q.push_back(32'h11111111); exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h33333333); exp_q.push_back(32'h44444444);
    run_read("rd_incr", 5'h00, 2'b01, 8'd3, 2'b00);

    exp_q.push_back(32'h33333333); exp_q.push_back(32'h44444444);
    exp_q.push_back(32'h11111111); exp_q.push_back(32'h22222222);
    run_read("rd_wrap", 5'h08, 2'b10, 8'd3, 2'b00);

    wr_gap = 1'b1; w_stall = 1'b1;
    wd_q.push_back(32'hAAAAAAAA); wd_q.push_back(32'hBBBBBBBB);
    wd_q.push_back(32'hCCCCCCCC); wd_q.push_back(32'hDDDDDDDD);
    run_write("wr_gap", 5'h10, 2'b01, 8'd3, 2'b00);
    wr_gap = 1'b0; w_stall = 1'b0; rd_toggle = 1'b1;
    exp_q.push_back(32'hAAAAAAAA); exp_q.push_back(32'hBBBBBBBB);
    exp_q.push_back(32'hCCCCCCCC); exp_q.push_back(32'hDDDDDDDD);
    run_read("rd_toggle", 5'h10, 2'b01, 8'd3, 2'b00);
    rd_toggle = 1'b0;

    run_illegal("ill_size3", 1'b1, 2'b01, 8'd0, 3'd3);
    run_illegal("ill_wrap2", 1'b0, 2'b10, 8'd2, 3'd2);
    run_illegal("ill_burst3", 1'b1, 2'b11, 8'd1, 3'd2);

    rlast_early = 1'b1;
    exp_q.push_back(32'h11111111); exp_q.push_back(32'h22222222);
    run_read("rd_early", 5'h00, 2'b01, 8'd3, 2'b10);
    rlast_early = 1'b0;

    bresp_cfg = 2'b01;
    wd_q.push_back(32'h00000001); wd_q.push_back(32'h00000002);
    run_write("wr_fixed", 5'h18, 2'b00, 8'd1, 2'b01);
    bresp_cfg = 2'b00;
    exp_q.push_back(32'h00000002); exp_q.push_back(32'h00000002);
    run_read("rd_fixed", 5'h18, 2'b00, 8'd1, 2'b00);

    for (int i = 0; i < 8; i++) wd_q.push_back(32'h70 + 32'(i));
    b0 = w_beats;
    send_cmd(1'b1, 5'h00, 2'b01, 8'd7, 3'd2, ok);
    check("mid_accept", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (w_beats - b0 >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_beat1_seen", 32'(ok), 32'd1);
    ARESET = 1'b0;
    d0 = done_cnt;
    @(negedge ACLK);
    check("mid_rst_outputs", out_vec(), 32'd0);
    check("mid_rst_resp", 32'(resp), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'd0);
    #1;
    flush_req++;
    ARESET = 1'b1;
    repeat (6) @(negedge ACLK);
    check("mid_no_done", 32'(done_cnt - d0), 32'd0);

    wd_q.push_back(32'h5A5A5A5A);
    run_write("wr_after_rst", 5'h1C, 2'b01, 8'd0, 2'b00);
    exp_q.push_back(32'h5A5A5A5A);
    run_read("rd_after_rst", 5'h1C, 2'b01, 8'd0, 2'b00);

    check("axi_valid_stable", 32'(viol), 32'd0);
    check("rready_follows", 32'(rr_mis), 32'd0);
    check("wvalid_follows", 32'(wv_mis), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
